// File: rtl/outport_alloc.sv
// Per-output-port allocator: arbiter request/QoS generation, wormhole lock, registered output stage.
// Optional statistics counters are enabled with `define OUTPORT_STATS_EN.
module outport_alloc #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DW    = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    in_valid,
    input  logic [WIDTH-1:0]    in_qos,
    input  logic [WIDTH-1:0]    in_last,
    input  logic [WIDTH*DW-1:0] in_data,
    output logic [WIDTH-1:0]    in_ready,
    output logic [WIDTH-1:0]    arb_req,
    output logic [WIDTH-1:0]    arb_qos,
    input  logic [WIDTH-1:0]    arb_gnt,
    output logic                out_valid,
    output logic                out_qos,
    output logic                out_last,
    output logic [DW-1:0]       out_data,
    input  logic                out_ready,
    output logic                busy
`ifdef OUTPORT_STATS_EN
    ,
    input  logic                stat_clr,
    output logic [31:0]         stat_flits,
    output logic [31:0]         stat_pkts,
    output logic [31:0]         stat_stall
`endif
);

    typedef enum logic {StIdle, StLocked} state_e;

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] owner_q, owner_d;
    logic             out_valid_q, out_valid_d;
    logic             out_qos_q, out_qos_d;
    logic             out_last_q, out_last_d;
    logic [DW-1:0]    out_data_q, out_data_d;

    logic [WIDTH-1:0] sel;
    logic             space, gnt_legal, xfer;
    logic             sel_qos, sel_last;
    logic [DW-1:0]    sel_data;

    // A multi-hot grant is illegal and is treated as no grant at all.
    assign gnt_legal = ((arb_gnt & (arb_gnt - One)) == '0);
    assign space     = !out_valid_q || out_ready;

    always_comb begin
        arb_req = '0;
        arb_qos = '0;
        sel     = '0;
        if (state_q == StIdle) begin
            arb_req = in_valid;
            arb_qos = in_valid & in_qos;
            if (gnt_legal) sel = arb_gnt;
        end else begin
            sel = owner_q;
        end
        if (!rst_n) begin
            arb_req = '0;
            arb_qos = '0;
        end
        in_ready = rst_n ? (sel & {WIDTH{space}}) : '0;
    end

    always_comb begin
        sel_data = '0;
        sel_qos  = 1'b0;
        sel_last = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sel[i]) begin
                sel_data = sel_data | in_data[i*DW +: DW];
                sel_qos  = sel_qos | in_qos[i];
                sel_last = sel_last | in_last[i];
            end
        end
    end

    assign xfer = (|(sel & in_valid)) && space;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        out_valid_d = out_valid_q;
        out_qos_d   = out_qos_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_qos_d   = sel_qos;
            out_last_d  = sel_last;
            out_data_d  = sel_data;
            if (state_q == StIdle && !sel_last) begin
                state_d = StLocked;
                owner_d = sel;
            end else if (state_q == StLocked && sel_last) begin
                state_d = StIdle;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            out_valid_q <= 1'b0;
            out_qos_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            out_valid_q <= out_valid_d;
            out_qos_q   <= out_qos_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_qos   = out_qos_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q == StLocked);

`ifdef OUTPORT_STATS_EN
    logic [31:0] flits_q, pkts_q, stall_q;
    logic        fire;

    assign fire = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flits_q <= '0;
            pkts_q  <= '0;
            stall_q <= '0;
        end else if (stat_clr) begin
            flits_q <= '0;
            pkts_q  <= '0;
            stall_q <= '0;
        end else begin
            if (fire && flits_q != '1) flits_q <= flits_q + 32'd1;
            if (fire && out_last_q && pkts_q != '1) pkts_q <= pkts_q + 32'd1;
            if (out_valid_q && !out_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
        end
    end

    assign stat_flits = flits_q;
    assign stat_pkts  = pkts_q;
    assign stat_stall = stall_q;
`endif

`ifndef SYNTHESIS
    gnt_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) gnt_legal)
        else $error("outport_alloc: multi-hot arb_gnt %b", arb_gnt);
`endif

endmodule

// File: tb/tb_outport_alloc.sv
// Bench for outport_alloc: vector table, directed corner sequences, random run vs a packet-level model.
module tb_outport_alloc;

    localparam int W  = 4;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  vld, qos, lst;
    logic [DW-1:0] dat [W];
    logic [W*DW-1:0] in_data;
    logic [W-1:0]  in_ready, arb_req, arb_qos, arb_gnt;
    logic          out_valid, out_qos, out_last, out_ready, busy;
    logic [DW-1:0] out_data;
    int            rr_ptr, rr_next;
    int            n_checks = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    assign in_data = {dat[3], dat[2], dat[1], dat[0]};

`ifdef OUTPORT_STATS_EN
    logic        stat_clr;
    logic [31:0] stat_flits, stat_pkts, stat_stall;
    int          m_flits, m_pkts, m_stall;
`endif

    // Stand-in QoS arbiter: high-QoS class wins, round-robin inside a class.
    function automatic logic [W-1:0] arb(input logic [W-1:0] req, input logic [W-1:0] q,
                                         input int ptr);
        logic [W-1:0] c;
        c = (q != '0) ? q : req;
        for (int k = 0; k < W; k++) begin
            if (c[(ptr + k) % W]) return W'(1 << ((ptr + k) % W));
        end
        return '0;
    endfunction

    always_comb arb_gnt = arb(arb_req, arb_qos, rr_ptr);

    outport_alloc #(.WIDTH(W), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (vld),
        .in_qos    (qos),
        .in_last   (lst),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .arb_req   (arb_req),
        .arb_qos   (arb_qos),
        .arb_gnt   (arb_gnt),
        .out_valid (out_valid),
        .out_qos   (out_qos),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef OUTPORT_STATS_EN
        ,
        .stat_clr  (stat_clr),
        .stat_flits(stat_flits),
        .stat_pkts (stat_pkts),
        .stat_stall(stat_stall)
`endif
    );

    // Model: owner channel index (-1 when no packet is open) plus the output flit slot.
    int            m_owner;
    logic          m_ov, m_oq, m_ol;
    logic [DW-1:0] m_od;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ov = 1'b0;
        m_oq = 1'b0;
        m_ol = 1'b0;
        m_od = '0;
`ifdef OUTPORT_STATS_EN
        m_flits = 0;
        m_pkts  = 0;
        m_stall = 0;
`endif
    endtask

    task automatic drive(input logic [W-1:0] v, input logic [W-1:0] q, input logic [W-1:0] l,
                         input logic [7:0] b, input logic ordy);
        vld = v;
        qos = q;
        lst = l;
        out_ready = ordy;
        for (int i = 0; i < W; i++) dat[i] = {48'h0, 8'(i), b};
    endtask

    // Checks the DUT against the model for the current inputs, then advances one clock.
    task automatic step();
        logic         space, xfer;
        logic [W-1:0] e_req, e_aq, g, e_rdy;
        int           s;
        #1;
        space = !m_ov || out_ready;
        s = -1;
        if (m_owner < 0) begin
            e_req = vld;
            e_aq  = vld & qos;
            g     = arb(e_req, e_aq, rr_ptr);
            for (int k = 0; k < W; k++) if (g[k]) s = k;
        end else begin
            e_req = '0;
            e_aq  = '0;
            s     = m_owner;
        end
        e_rdy = (s >= 0 && space) ? W'(1 << s) : '0;
        xfer  = (s >= 0) && vld[s] && space;
        chk("arb_req", arb_req, e_req);
        chk("arb_qos", arb_qos, e_aq);
        chk("in_ready", in_ready, e_rdy);
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_od);
        chk("out_qos", out_qos, m_oq);
        chk("out_last", out_last, m_ol);
        chk("busy", busy, m_owner >= 0);
`ifdef OUTPORT_STATS_EN
        chk("stat_flits", stat_flits, m_flits);
        chk("stat_pkts", stat_pkts, m_pkts);
        chk("stat_stall", stat_stall, m_stall);
        if (m_ov && out_ready) begin
            m_flits++;
            if (m_ol) m_pkts++;
        end
        if (m_ov && !out_ready) m_stall++;
`endif
        rr_next = rr_ptr;
        if (xfer) begin
            if (m_owner < 0) begin
                rr_next = (s + 1) % W;
                if (!lst[s]) m_owner = s;
            end else if (lst[s]) begin
                m_owner = -1;
            end
            m_ov = 1'b1;
            m_od = dat[s];
            m_oq = qos[s];
            m_ol = lst[s];
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
        rr_ptr = rr_next;
    endtask

    typedef struct {
        logic [W-1:0] v, q, l;
        logic [7:0]   d;
        logic         ordy;
        logic [W-1:0] e_rdy, e_aq;
        logic         e_ov, e_busy;
        logic [15:0]  e_od;
    } vec_t;

    vec_t vecs [10];

    initial begin
        // Single 3-flit packet on ch0, then ch3 (high QoS) beating ch1, then masked QoS.
        vecs[0] = '{4'b0001, 4'b0000, 4'b0000, 8'hA1, 1'b1, 4'b0001, 4'b0000, 1'b0, 1'b0, 16'h0000};
        vecs[1] = '{4'b0001, 4'b0000, 4'b0000, 8'hA2, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1, 16'h00A1};
        vecs[2] = '{4'b0001, 4'b0000, 4'b0001, 8'hA3, 1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1, 16'h00A2};
        vecs[3] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'h00A3};
        vecs[4] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h00A3};
        vecs[5] = '{4'b1010, 4'b1000, 4'b0000, 8'hB1, 1'b1, 4'b1000, 4'b1000, 1'b0, 1'b0, 16'h00A3};
        vecs[6] = '{4'b1010, 4'b1000, 4'b1000, 8'hB2, 1'b1, 4'b1000, 4'b0000, 1'b1, 1'b1, 16'h03B1};
        vecs[7] = '{4'b0010, 4'b0000, 4'b0010, 8'hB3, 1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 16'h03B2};
        vecs[8] = '{4'b0000, 4'b1111, 4'b0000, 8'h00, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'h01B3};
        vecs[9] = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 16'h01B3};

        rst_n = 1'b0;
        rr_ptr = 0;
`ifdef OUTPORT_STATS_EN
        stat_clr = 1'b0;
`endif
        drive(4'b1111, 4'b1111, 4'b0000, 8'h55, 1'b1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_in_ready", in_ready, 4'b0000);
        chk("rst_arb_req", arb_req, 4'b0000);
        drive(4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1);
        rst_n = 1'b1;

        for (int r = 0; r < 10; r++) begin
            drive(vecs[r].v, vecs[r].q, vecs[r].l, vecs[r].d, vecs[r].ordy);
            #1;
            chk($sformatf("vec%0d_in_ready", r), in_ready, vecs[r].e_rdy);
            chk($sformatf("vec%0d_arb_qos", r), arb_qos, vecs[r].e_aq);
            chk($sformatf("vec%0d_out_valid", r), out_valid, vecs[r].e_ov);
            chk($sformatf("vec%0d_busy", r), busy, vecs[r].e_busy);
            chk($sformatf("vec%0d_out_data", r), out_data, 64'(vecs[r].e_od));
            step();
        end

        // Lock hold: ch2 owns the port, ch0 raises high QoS and must wait for ch2's tail.
        drive(4'b0100, 4'b0000, 4'b0000, 8'hC1, 1'b1);
        step();
        drive(4'b0101, 4'b0001, 4'b0000, 8'hC2, 1'b1);
        #1;
        chk("lock_in_ready", in_ready, 4'b0100);
        chk("lock_arb_req", arb_req, 4'b0000);
        step();
        drive(4'b0101, 4'b0001, 4'b0100, 8'hC3, 1'b1);
        step();
        drive(4'b0001, 4'b0001, 4'b0000, 8'hD1, 1'b1);
        #1;
        chk("unlock_in_ready", in_ready, 4'b0001);
        chk("unlock_arb_qos", arb_qos, 4'b0001);
        step();
        drive(4'b0001, 4'b0001, 4'b0001, 8'hD2, 1'b1);
        step();
        drive(4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1);
        repeat (2) step();

        // Backpressure: 5 stalled cycles mid-packet on ch1.
        drive(4'b0010, 4'b0000, 4'b0000, 8'hE1, 1'b1);
        step();
        drive(4'b0010, 4'b0000, 4'b0000, 8'hE2, 1'b1);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(4'b0010, 4'b0000, 4'b0000, 8'hE3, 1'b0);
            #1;
            chk("stall_out_data", out_data, 64'h1E2);
            chk("stall_in_ready", in_ready, 4'b0000);
            step();
        end
        drive(4'b0010, 4'b0000, 4'b0000, 8'hE3, 1'b1);
        step();
        drive(4'b0010, 4'b0000, 4'b0010, 8'hE4, 1'b1);
        step();
        drive(4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1);
        repeat (2) step();

        // Back-to-back single-flit packets from ch0 and ch1: no bubbles, alternating.
        rr_ptr = 0;
        drive(4'b0011, 4'b0000, 4'b0011, 8'hF0, 1'b1);
        step();
        for (int k = 0; k < 8; k++) begin
            drive(4'b0011, 4'b0000, 4'b0011, 8'hF0, 1'b1);
            #1;
            chk("b2b_out_valid", out_valid, 1'b1);
            chk("b2b_channel", out_data[15:8], 8'(k % 2));
            step();
        end
        drive(4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1);
        repeat (2) step();

        // Reset while locked drops the output flit at once.
        drive(4'b0100, 4'b0000, 4'b0000, 8'h61, 1'b1);
        step();
        drive(4'b0100, 4'b0000, 4'b0000, 8'h62, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_in_ready", in_ready, 4'b0000);
`ifdef OUTPORT_STATS_EN
        chk("midrst_stat_flits", stat_flits, 32'd0);
        chk("midrst_stat_pkts", stat_pkts, 32'd0);
        chk("midrst_stat_stall", stat_stall, 32'd0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(4'b0000, 4'b0000, 4'b0000, 8'h00, 1'b1);
        repeat (2) step();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            vld = W'($urandom);
            qos = W'($urandom);
            for (int i = 0; i < W; i++) begin
                lst[i] = ($urandom_range(0, 2) == 0);
                dat[i] = {$urandom, $urandom};
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
